// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg: fixed-point constants, FSM states and helpers for the 2-2-1 XOR forward engine
package nn_fixed_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ONE = 1 << FRAC_W;
  localparam int HALF = ONE / 2;
  localparam logic [16:0] SIG_SAT = 17'd1280;
  localparam logic [16:0] SIG_BP1 = 17'd608;
  localparam logic [16:0] SIG_BP2 = 17'd256;
  localparam logic [16:0] SIG_OF1 = 17'd216;
  localparam logic [16:0] SIG_OF2 = 17'd160;
  localparam logic [16:0] SIG_OF3 = 17'd128;
  typedef enum logic [2:0] {S_IDLE, S_H1X1, S_H1X2, S_H2X1, S_H2X2, S_YH1, S_YH2, S_SIG} state_t;
  localparam logic [15:0] NN_W11_INIT = 16'h0200;
  localparam logic [15:0] NN_W12_INIT = 16'h0180;
  localparam logic [15:0] NN_W21_INIT = 16'hFF00;
  localparam logic [15:0] NN_W22_INIT = 16'h0140;
  localparam logic [15:0] NN_W31_INIT = 16'h0120;
  localparam logic [15:0] NN_W32_INIT = 16'hFF40;
  localparam logic [15:0] NN_B1_INIT  = 16'h0010;
  localparam logic [15:0] NN_B2_INIT  = 16'hFFE0;
  localparam logic [15:0] NN_B3_INIT  = 16'h0008;
  // bank order: w11,w12,w21,w22,w31,w32,b1,b2,b3 at indices 0..8
  localparam logic [8:0][15:0] NN_INIT = {NN_B3_INIT, NN_B2_INIT, NN_B1_INIT, NN_W32_INIT,
    NN_W31_INIT, NN_W22_INIT, NN_W21_INIT, NN_W12_INIT, NN_W11_INIT};
  function automatic logic [15:0] sat16(input logic signed [32:0] v);
    return v > 33'sd32767 ? 16'h7FFF : v < -33'sd32768 ? 16'h8000 : v[15:0];
  endfunction
  function automatic logic signed [32:0] round_q8(input logic signed [32:0] acc);
    return (acc + 33'sd128) >>> FRAC_W;
  endfunction
endpackage

// File: rtl/sigmoid_plan.sv
// sigmoid_plan: piecewise-linear (PLAN) sigmoid, 8.8 z in, 0..256 y out
//   i_z  in  16  signed pre-activation
//   o_y  out 16  sigmoid(z) in 8.8
module sigmoid_plan
  import nn_fixed_pkg::*;
(
  input  logic [15:0] i_z,
  output logic [15:0] o_y
);
  logic [16:0] w_a, w_f;
  // 17-bit magnitude keeps |-32768| representable
  assign w_a = i_z[15] ? ~{i_z[15], i_z} + 17'd1 : {1'b0, i_z};
  assign w_f = w_a >= SIG_SAT ? 17'd256 : w_a >= SIG_BP1 ? (w_a >> 5) + SIG_OF1 :
               w_a >= SIG_BP2 ? (w_a >> 3) + SIG_OF2 : (w_a >> 2) + SIG_OF3;
  assign o_y = i_z[15] ? 16'(17'd256 - w_f) : w_f[15:0];
endmodule

// File: rtl/forward_propagation_engine.sv
// forward_propagation_engine: time-multiplexed forward pass of a 2-2-1 network with live/shadow weight banks
//   clk, rst (async, active-high); start/x1/x2 launch a pass; load_valid + *_in update weights
//   *_q live weights; h1/h2/y results; busy outside IDLE; valid one-cycle pulse on new results
module forward_propagation_engine
  import nn_fixed_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic        load_valid,
  input  logic [15:0] w11_in, w12_in, w21_in, w22_in, w31_in, w32_in, b1_in, b2_in, b3_in,
  output logic [15:0] w11_q, w12_q, w21_q, w22_q, w31_q, w32_q, b1_q, b2_q, b3_q,
  output logic [15:0] h1,
  output logic [15:0] h2,
  output logic [15:0] y,
  output logic        busy,
  output logic        valid
);
  state_t r_state, w_next;
  logic [8:0][15:0] r_w, r_s, w_in;
  logic [15:0] r_x1, r_x2, r_h1i, r_h2i, r_z, r_h1, r_h2, r_y;
  logic [15:0] w_op, w_b, w_res, w_relu, w_y;
  logic [31:0] r_acc, w_prod, w_sum;
  logic [2:0] w_idx;
  logic r_pend, r_valid, w_idle, w_sig, w_first, w_comp;
  assign w_in = {b3_in, b2_in, b1_in, w32_in, w31_in, w22_in, w21_in, w12_in, w11_in};
  assign {b3_q, b2_q, b1_q, w32_q, w31_q, w22_q, w21_q, w12_q, w11_q} = r_w;
  assign w_idle = r_state == S_IDLE;
  assign w_sig = r_state == S_SIG;
  assign w_comp = !w_idle && !w_sig;
  assign w_first = r_state == S_H1X1 || r_state == S_H2X1 || r_state == S_YH1;
  always_comb begin
    w_next = w_idle ? (start ? S_H1X1 : S_IDLE) : w_sig ? S_IDLE : state_t'(r_state + 3'd1);
  end
  // compute states H1X1..YH2 map in order onto weights w11..w32
  assign w_idx = 3'(r_state - 3'd1);
  assign w_op = r_state == S_YH1 ? r_h1i : r_state == S_YH2 ? r_h2i :
                (r_state == S_H1X1 || r_state == S_H2X1) ? r_x1 : r_x2;
  assign w_b = r_state == S_H1X1 ? r_w[6] : r_state == S_H2X1 ? r_w[7] : r_w[8];
  assign w_prod = 32'($signed(r_w[w_idx]) * $signed(w_op));
  assign w_sum = (w_first ? {{8{w_b[15]}}, w_b, 8'd0} : r_acc) + w_prod;
  assign w_res = sat16(round_q8({w_sum[31], w_sum}));
  assign w_relu = w_res[15] ? 16'd0 : w_res;
  sigmoid_plan u_sig (.i_z(r_z), .o_y(w_y));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_w <= NN_INIT;
      r_s <= '0;
      r_pend <= 1'b0;
      r_valid <= 1'b0;
      {r_x1, r_x2, r_h1i, r_h2i, r_z, r_h1, r_h2, r_y} <= '0;
      r_acc <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= w_sig;
      if (w_idle && start) {r_x1, r_x2} <= {x1, x2};
      if (w_comp) r_acc <= w_sum;
      if (r_state == S_H1X2) r_h1i <= w_relu;
      if (r_state == S_H2X2) r_h2i <= w_relu;
      if (r_state == S_YH2) r_z <= w_res;
      if (w_sig) {r_h1, r_h2, r_y} <= {r_h1i, r_h2i, w_y};
      // a load arriving on the commit cycle is newer than the shadow, so it wins
      if (load_valid && (w_idle || w_sig)) r_w <= w_in;
      else if (w_sig && r_pend) r_w <= r_s;
      if (load_valid && w_comp) begin
        r_s <= w_in;
        r_pend <= 1'b1;
      end else if (w_sig) r_pend <= 1'b0;
    end
  end
  assign {h1, h2, y} = {r_h1, r_h2, r_y};
  assign busy = !w_idle;
  assign valid = r_valid;
endmodule

// File: tb/tb_forward_propagation_engine.sv
// tb_forward_propagation_engine: directed self-checking bench for forward_propagation_engine
module tb_forward_propagation_engine;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, load_valid = 1'b0;
  logic [15:0] x1 = '0, x2 = '0, tz = '0;
  logic [8:0][15:0] win = '0;
  logic [8:0][15:0] wq;
  logic [15:0] h1, h2, y, ty;
  logic busy, valid;
  int errs = 0, checks = 0;
  localparam logic [8:0][15:0] INIT = {16'h0008, 16'hFFE0, 16'h0010, 16'hFF40, 16'h0120,
    16'h0140, 16'hFF00, 16'h0180, 16'h0200};
  localparam logic [8:0][15:0] ZERO = '0;
  localparam logic [8:0][15:0] T2 = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'hFF00, 16'hFF00, 16'h0100, 16'h0100};
  localparam logic [8:0][15:0] T3 = {16'h0, 16'h0, 16'h0, 16'h0, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0100, 16'h0100};
  localparam logic [8:0][15:0] T4 = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF};
  always #5 clk = ~clk;
  forward_propagation_engine dut (
    .clk(clk), .rst(rst), .start(start), .x1(x1), .x2(x2), .load_valid(load_valid),
    .w11_in(win[0]), .w12_in(win[1]), .w21_in(win[2]), .w22_in(win[3]), .w31_in(win[4]),
    .w32_in(win[5]), .b1_in(win[6]), .b2_in(win[7]), .b3_in(win[8]),
    .w11_q(wq[0]), .w12_q(wq[1]), .w21_q(wq[2]), .w22_q(wq[3]), .w31_q(wq[4]),
    .w32_q(wq[5]), .b1_q(wq[6]), .b2_q(wq[7]), .b3_q(wq[8]),
    .h1(h1), .h2(h2), .y(y), .busy(busy), .valid(valid));
  sigmoid_plan u_sig (.i_z(tz), .o_y(ty));
  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [8:0][15:0] v);
    @(negedge clk);
    win = v;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask
  task automatic pass(input logic [15:0] a, input logic [15:0] b, input string tag);
    int n;
    @(negedge clk);
    x1 = a;
    x2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 144'(n), 144'd8);
    @(negedge clk);
    chk({tag, "_pulse"}, 144'(valid), 144'd0);
  endtask
  task automatic sig(input logic [15:0] z, input logic [15:0] e);
    tz = z;
    #1;
    chk($sformatf("sig_%0h", z), 144'(ty), 144'(e));
  endtask
  initial begin
    int nv;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out", {h1, h2, y, busy, valid}, 144'd0);
    chk("rst_w", wq, INIT);
    load(ZERO);
    chk("load_idle", wq, ZERO);
    pass(16'd256, 16'd256, "t1");
    chk("t1_out", {h1, h2, y}, {16'd0, 16'd0, 16'd128});
    load(T2);
    pass(16'd256, 16'd256, "t2");
    chk("t2_out", {h1, h2, y}, {16'd512, 16'd0, 16'd224});
    pass(16'hFF00, 16'hFF00, "t3a");
    chk("t3a_out", {h1, h2, y}, {16'd0, 16'd512, 16'd128});
    load(T3);
    pass(16'd256, 16'd256, "t3b");
    chk("t3b_out", {h1, h2, y}, {16'd512, 16'd0, 16'd32});
    load(T4);
    pass(16'h7FFF, 16'h1234, "t4");
    chk("t4_h1sat", 144'(h1), 144'h7FFF);
    sig(16'd256, 16'd192);
    sig(16'hFF00, 16'd64);
    sig(16'd2000, 16'd256);
    sig(16'h8000, 16'd0);
    sig(16'd0, 16'd128);
    load(T2);
    @(negedge clk);
    x1 = 16'd256;
    x2 = 16'd256;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    win = T3;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    chk("t5_shadow_hold", wq, T2);
    repeat (4) @(negedge clk);
    chk("t5_valid", 144'(valid), 144'd1);
    chk("t5_old_w", 144'(y), 144'd224);
    chk("t5_commit", wq, T3);
    @(negedge clk);
    chk("t5_no_queue", {valid, busy}, 144'd0);
    @(negedge clk);
    chk("t5_idle", 144'(busy), 144'd0);
    pass(16'd256, 16'd256, "t5b");
    chk("t5b_new_w", 144'(y), 144'd32);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_out", {h1, h2, y, busy, valid}, 144'd0);
    chk("t6_w", wq, INIT);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      nv += int'(valid);
    end
    chk("t6_no_valid", 144'(nv), 144'd0);
    pass(16'd256, 16'd256, "t6b");
    chk("t6b_out", {h1, h2, y}, {16'h0390, 16'h0020, 16'd247});
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
